// File: rtl/upk_bank_arbiter_if.sv
// Request/response bus between two register-programming requesters and
// upk_bank_arbiter.
//   req_valid/req_write : per-requester request valid and direction (1 = write)
//   req_addr/req_wdata  : per-requester entry index and write data, requester i
//                         at [i*W +: W]
//   req_ready           : per-requester grant (at most one bit high)
//   rsp_valid/rsp_rdata : per-requester read response valid, shared read data
interface upk_bank_arbiter_if #(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned DATA_W      = 8
);
  localparam int unsigned ADDR_W = $clog2(NUM_ENTRIES);

  logic [1:0]          req_valid;
  logic [1:0]          req_write;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          req_ready;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/upk_bank_arbiter.sv
// Two-requester round-robin controller for a working register bank with a
// shadow copy refreshed atomically on commit.
//   clk, reset    : clock, asynchronous active-high reset
//   bus           : request/response bus (slave side)
//   commit_req_i  : copy working array into shadow array
//   commit_done_o : one-cycle pulse when the shadow has been updated
//   shadow_out_o  : shadow array, entry k at [k*DATA_W +: DATA_W]
module upk_bank_arbiter #(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned DATA_W      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  upk_bank_arbiter_if.slave             bus,
  input  logic                          commit_req_i,
  output logic                          commit_done_o,
  output logic [NUM_ENTRIES*DATA_W-1:0] shadow_out_o
);
  localparam int unsigned ADDR_W = $clog2(NUM_ENTRIES);

  typedef enum logic [0:0] {StIdle, StCommit} state_e;

  state_e              state_q, state_d;
  logic                last_q, last_d;  // index of the most recently granted requester
  logic [1:0]          grant;
  logic                gwrite;
  logic [ADDR_W-1:0]   gaddr;
  logic [DATA_W-1:0]   gwdata;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   work_q   [NUM_ENTRIES];
  logic [DATA_W-1:0]   shadow_q [NUM_ENTRIES];
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                commit_done_q, commit_done_d;

  // Arbitration and commit sequencing.
  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    grant         = 2'b00;
    commit_done_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (!reset) begin
          if (bus.req_valid == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
          end else begin
            grant = bus.req_valid;
          end
        end
        if (commit_req_i) state_d = StCommit;
      end
      StCommit: begin
        // commit_req_i is deliberately ignored here; it is not queued.
        state_d       = StIdle;
        commit_done_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    if (grant != 2'b00) last_d = grant[1];
  end

  // Fields of the granted requester.
  always_comb begin
    gwrite = grant[1] ? bus.req_write[1] : bus.req_write[0];
    gaddr  = grant[1] ? bus.req_addr[ADDR_W +: ADDR_W] : bus.req_addr[0 +: ADDR_W];
    gwdata = grant[1] ? bus.req_wdata[DATA_W +: DATA_W] : bus.req_wdata[0 +: DATA_W];
  end

  // Out-of-range indices match no entry, so reads return 0 and writes drop.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      if (gaddr == ADDR_W'(k)) rd_word = work_q[k];
    end
  end

  always_comb begin
    rsp_valid_d = gwrite ? 2'b00 : grant;
    rsp_rdata_d = rsp_rdata_q;
    if (grant != 2'b00 && !gwrite) rsp_rdata_d = rd_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      last_q        <= 1'b1;  // favours requester 0 on the first contended cycle
      rsp_valid_q   <= '0;
      rsp_rdata_q   <= '0;
      commit_done_q <= 1'b0;
      for (int k = 0; k < NUM_ENTRIES; k++) begin
        work_q[k]   <= '0;
        shadow_q[k] <= '0;
      end
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      commit_done_q <= commit_done_d;
      for (int k = 0; k < NUM_ENTRIES; k++) begin
        if (grant != 2'b00 && gwrite && gaddr == ADDR_W'(k)) work_q[k] <= gwdata;
        if (state_q == StCommit) shadow_q[k] <= work_q[k];
      end
    end
  end

  assign bus.req_ready  = grant;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign commit_done_o  = commit_done_q;

  for (genvar k = 0; k < NUM_ENTRIES; k++) begin : g_shadow
    assign shadow_out_o[k*DATA_W +: DATA_W] = shadow_q[k];
  end
endmodule

// File: doc/upk_bank_arbiter.md
# upk_bank_arbiter

Arbitrated controller for a small unpacked register bank: a working array of NUM_ENTRIES x DATA_W entries shared by two requesters, plus a shadow array refreshed by a whole-array copy on command. Requesters issue single-entry reads and writes through a valid/ready handshake under round-robin arbitration. A commit sequence freezes the bank for one cycle and copies working to shadow atomically. It sits between register-programming agents and the datapath that consumes the shadow contents.

## Interface
- NUM_ENTRIES, 4, number of entries in the working and shadow arrays (2..16)
- DATA_W, 8, width of each entry in bits
- ADDR_W, $clog2(NUM_ENTRIES), entry index width (derived, not overridden)

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  2  per-requester request valid (bit i = requester i)
- req_write  input  2  per-requester: 1 = write, 0 = read
- req_addr  input  2*ADDR_W  per-requester entry index, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  input  2*DATA_W  per-requester write data, same packing
- req_ready  output  2  per-requester grant, combinational; at most one bit high
- rsp_valid  output  2  per-requester read response valid, registered
- rsp_rdata  output  DATA_W  read data, valid when any rsp_valid bit is high
- commit_req  input  1  request to copy working array into shadow array
- commit_done  output  1  one-cycle pulse: shadow updated
- shadow_out  output  NUM_ENTRIES*DATA_W  shadow array flattened, entry k at [k*DATA_W +: DATA_W]

## Operation
- States: IDLE, COMMIT. Reset -> IDLE.
- IDLE, no commit_req: grant one valid requester per cycle. If both are valid, grant the one not granted last (last_grant pointer). After reset the pointer favours requester 0.
- The pointer updates only on an actual grant.
- A transfer occurs when req_valid[i] and req_ready[i] are both high.
- Granted write: working[addr] <= wdata at that edge.
- Granted read: rsp_valid[i] high next cycle. rsp_rdata carries working[addr] as sampled in the grant cycle.
- Address >= NUM_ENTRIES: the write is discarded; the read returns 0. The handshake completes normally.
- IDLE with commit_req high: grants still occur in that cycle. Next state is COMMIT.
- COMMIT (exactly one cycle): req_ready = 0. At the closing edge, shadow <= working, commit_done <= 1, next state IDLE.
- commit_req high while in COMMIT is ignored and not queued.
- Shadow changes only via commit.
- Requesters must hold req_valid, req_write, req_addr and req_wdata stable until granted.
- Reset values: working and shadow all 0; shadow_out = 0; rsp_valid = 0; rsp_rdata = 0; commit_done = 0; req_ready = 0 while reset is asserted.

## Timing
- Write latency: visible to a read granted on the following cycle.
- Read latency: 1 cycle, grant to rsp_valid.
- Commit: commit_req sampled at edge T. COMMIT state during cycle T+1. shadow_out and commit_done updated at edge T+2. commit_done is high for cycle T+2 only.
- A write granted in the same cycle as commit_req is included in the copy.
- No grant is issued during the COMMIT cycle. Pending requests resume in the following IDLE cycle with round-robin order preserved.
- Back-to-back commits (commit_req high at T and T+2): two COMMIT cycles and two commit_done pulses.
- Sustained throughput: one access per cycle outside COMMIT.
- Reset asserted mid-commit: returns to IDLE immediately, shadow cleared, no commit_done.

## Test plan
- Reset, then requester 0 writes 10, 20, 30, 40 to entries 0..3 and commits -> commit_done one cycle, shadow_out = 0x281E140A.
- Both requesters continuously valid, reading entry 1 -> req_ready alternates 01, 10, 01, 10; each rsp_valid bit follows its grant by 1 cycle.
- commit_req in the same cycle as a requester-1 write of 0x55 to entry 2 -> the write completes, the next cycle has no grant, shadow entry 2 = 0x55.
- With NUM_ENTRIES = 3: write 0xAA to address 3, then read it -> handshakes complete, the read returns 0, working array unchanged.
- Assert reset during the COMMIT cycle after prior nonzero writes -> commit_done stays 0, shadow_out = 0; a read of entry 0 after reset returns 0.
- commit_req held high for 4 cycles -> commit_done pulses on two cycles (T+2, T+4); no grants during either COMMIT cycle.
